ifm_window_gen: RTL



---
 rtl/cnn_pkg.sv | 8 +
 rtl/ifm_window_gen_if.sv | 11 +
 rtl/line_buffer.sv | 21 ++
 rtl/ifm_window_gen.sv | 116 +++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: kernel geometry, window-generator states and pixel type.
package cnn_pkg;
    localparam int KERNEL_DIM = 3;
    localparam int IFM_PIX_W  = 8;

    typedef enum logic [1:0] {IDLE, RUN, DONE} win_state_t;
    typedef logic signed [IFM_PIX_W-1:0] ifm_pix_t;
endpackage

// File: rtl/ifm_window_gen_if.sv
// Pixel stream into the window generator: valid/data from the source, ready back.
interface ifm_window_gen_if #(
    parameter int INPUT_IFM_WIDTH = 8
);
    logic                               pix_valid;
    logic signed [INPUT_IFM_WIDTH-1:0]  pix_data;
    logic                               pix_ready;

    modport master (output pix_valid, output pix_data, input  pix_ready);
    modport slave  (input  pix_valid, input  pix_data, output pix_ready);
endinterface

// File: rtl/line_buffer.sv
// One image row of storage: combinational read at addr, write on the clock edge when we is set.
module line_buffer #(
    parameter  int DEPTH = 28,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    // Contents need no reset: every location is rewritten before a window uses it.
    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end
endmodule

// File: rtl/ifm_window_gen.sv
// Streaming 3x3 window generator: two chained line buffers plus a 3x3 shift register,
// emitting one window per accepted pixel once two full rows and two columns are buffered.
module ifm_window_gen
    import cnn_pkg::*;
#(
    parameter int INPUT_IFM_WIDTH = 8,
    parameter int IMG_W           = 28,
    parameter int IMG_H           = 28,
    parameter int PE_ARR_SIZE     = 9
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        start,
    ifm_window_gen_if.slave                             pix_if,
    output logic [PE_ARR_SIZE-1:0][INPUT_IFM_WIDTH-1:0] ifm_window,
    output logic                                        ready_load,
    output logic                                        busy,
    output logic                                        frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef logic [INPUT_IFM_WIDTH-1:0] pix_t;

    win_state_t state, state_nxt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          accept, last_col, last_pix, emit;
    pix_t          lb0_rd, lb1_rd;
    logic [PE_ARR_SIZE-1:0][INPUT_IFM_WIDTH-1:0] win_q, win_d;

    assign accept   = pix_if.pix_valid && (state == RUN);
    assign last_col = (col == CW'(IMG_W - 1));
    assign last_pix = last_col && (row == RW'(IMG_H - 1));
    // Row/col are pre-increment here, so this selects pixels completing a full 3x3 window.
    assign emit     = accept && (row >= RW'(2)) && (col >= CW'(2));

    assign pix_if.pix_ready = (state == RUN);
    assign busy             = (state != IDLE);
    assign frame_done       = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (accept && last_pix) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (state == IDLE && start) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (last_col) begin
                col <= '0;
                row <= last_pix ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // lb0 holds the previous row, lb1 the one before; each accept ages column col by one row.
    line_buffer #(.DEPTH(IMG_W), .WIDTH(INPUT_IFM_WIDTH)) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (col),
        .wdata (pix_if.pix_data),
        .rdata (lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(INPUT_IFM_WIDTH)) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (col),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    // Element r*3+c is row r (0 = oldest), column c (0 = leftmost); new column enters at c = 2.
    always_comb begin
        win_d = win_q;
        for (int r = 0; r < KERNEL_DIM; r++) begin
            for (int c = 0; c < KERNEL_DIM - 1; c++) begin
                win_d[r*KERNEL_DIM + c] = win_q[r*KERNEL_DIM + c + 1];
            end
        end
        win_d[KERNEL_DIM - 1]   = lb1_rd;
        win_d[2*KERNEL_DIM - 1] = lb0_rd;
        win_d[3*KERNEL_DIM - 1] = pix_if.pix_data;
    end

    // The exposed window is a separate register so it holds steady between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q      <= '0;
            ifm_window <= '0;
            ready_load <= 1'b0;
        end else begin
            ready_load <= emit;
            if (accept) win_q      <= win_d;
            if (emit)   ifm_window <= win_d;
        end
    end
endmodule
